imem_read_arbiter: RTL and testbench
====================================

// Module: imem_read_arbiter
// PURPOSE
//  Shares the single read port of the instruction memory between two requesters:
//  port 0 = fetch stage (priority), port 1 = debug/monitor reader.
//  Issues one address per cycle to the memory and tracks the 1-cycle read latency.
//  The memory registers the address on clk and returns insn the next cycle.
//  Routes each returned insn to the requester that owns it.
//  Port 1 has a bounded-wait guarantee via a starvation counter.
// PARAMETERS
//  STARVE_LIMIT  4  max consecutive cycles port 1 may be refused while valid; range 1..255
//  INSN_ADDR_WIDTH, INSN_WIDTH come from Types/BasicTypes; they are not module parameters
// PORTS
//  clk         in   1                clock
//  rst         in   1                reset; synchronous, active-low
//  req0_valid  in   1                fetch read request
//  req0_addr   in   INSN_ADDR_WIDTH  fetch byte address
//  req0_ready  out  1                fetch request accepted this cycle
//  rsp0_valid  out  1                rsp0_insn valid (fetch)
//  rsp0_insn   out  INSN_WIDTH       instruction returned to fetch
//  req1_valid  in   1                debug read request
//  req1_addr   in   INSN_ADDR_WIDTH  debug byte address
//  req1_ready  out  1                debug request accepted this cycle
//  rsp1_valid  out  1                rsp1_insn valid (debug)
//  rsp1_insn   out  INSN_WIDTH       instruction returned to debug
//  mem_addr    out  INSN_ADDR_WIDTH  address to instruction memory (latched by memory on clk)
//  mem_insn    in   INSN_WIDTH       memory read data for address latched last edge
//  starve_cnt  out  8                current port-1 refusal count (debug visibility)
// BEHAVIOUR
//  - Reset: rst sampled low at posedge clk -> owner_q=NONE, starve_q=0, hold_addr_q=0.
//    While rst=0: req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, mem_addr=0.
//  - Grant (combinational, per cycle, rst=1):
//    - force1 = req1_valid && starve_q>=STARVE_LIMIT.
//    - gnt1 = req1_valid && (force1 || !req0_valid).
//    - gnt0 = req0_valid && !gnt1.
//    - At most one grant per cycle. reqN_ready=gntN; a request transfers when valid&&ready.
//  - Address mux: mem_addr = gnt0 ? req0_addr : gnt1 ? req1_addr : hold_addr_q.
//    hold_addr_q <= mem_addr every cycle, so mem_addr never toggles when idle.
//  - Owner register: owner_q <= gnt0 ? R0 : gnt1 ? R1 : NONE.
//  - Response: latency exactly 1 cycle after grant.
//    - rsp0_valid = (owner_q==R0); rsp1_valid = (owner_q==R1).
//    - rsp0_insn = rsp1_insn = mem_insn, unregistered.
//    - Responses are not buffered: a requester must sample rspN in the valid cycle.
//    - Back-to-back grants give one response per cycle, in grant order.
//  - Starvation counter (8 bit, saturating at 255):
//    - starve_q <= 0 when gnt1 or !req1_valid.
//    - starve_q <= starve_q+1 when req1_valid && !gnt1.
//  - Boundaries:
//    - Both valid with starve_q<LIMIT -> port 0 wins.
//    - With starve_q==LIMIT -> port 1 wins and the counter clears.
//    - req1 dropped mid-wait -> counter clears.
//    - reset asserted with owner_q!=NONE -> pending response discarded, no rspN_valid next cycle.
//    - First cycle after reset release: no response, even if mem_insn is nonzero.
//  - No FSM beyond owner_q {NONE,R0,R1}; all state updates on posedge clk only.
// TESTING
//  1 Reset: rst=0 with both reqs valid -> readies 0, rsp valids 0, mem_addr=0; after release
//    owner NONE.
//  2 Fetch only: req0 addr 0x0,0x4,0x8 on consecutive cycles -> req0_ready=1 each cycle,
//    mem_addr follows, rsp0_valid 1 cycle later each, insn = mem words 0,1,2.
//  3 Contention, STARVE_LIMIT=4: req0 and req1 valid continuously -> port 0 granted 4 cycles,
//    port 1 granted on cycle 5 (starve_cnt 0,1,2,3,4,0), pattern repeats; rsp1_valid 1 cycle
//    after its grant.
//  4 Idle hold: grant req0 addr 0x10, then no requests 3 cycles -> mem_addr stays 0x10,
//    no rsp valids after the first response.
//  5 Reset mid-flight: grant req1 addr 0x20, rst=0 next edge -> rsp1_valid stays 0,
//    starve_cnt=0, owner NONE.
//  6 Debug only: req1 valid alone -> granted every cycle, starve_cnt stays 0,
//    rsp1 stream matches memory contents.

Source files
------------

// File: rtl/imem_read_arbiter.sv
// imem_read_arbiter
//   Shares the single instruction-memory read port between the fetch stage
//   (port 0, priority) and a debug/monitor reader (port 1). One address is
//   issued per cycle and the returned word is routed to the owner one cycle
//   later. A starvation counter bounds how long port 1 can be refused.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   req0_valid/addr/ready     fetch request handshake
//   rsp0_valid/insn           fetch response (valid for exactly one cycle)
//   req1_valid/addr/ready     debug request handshake
//   rsp1_valid/insn           debug response (valid for exactly one cycle)
//   mem_addr                  address to memory, latched by memory on clk
//   mem_insn                  memory data for the address latched last edge
//   starve_cnt                current port-1 refusal count

package imem_types_pkg;
  localparam int INSN_ADDR_WIDTH = 32;
  localparam int INSN_WIDTH      = 32;
endpackage

module imem_read_arbiter
  import imem_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [INSN_ADDR_WIDTH-1:0] req0_addr,
  output logic                       req0_ready,
  output logic                       rsp0_valid,
  output logic [INSN_WIDTH-1:0]      rsp0_insn,
  input  logic                       req1_valid,
  input  logic [INSN_ADDR_WIDTH-1:0] req1_addr,
  output logic                       req1_ready,
  output logic                       rsp1_valid,
  output logic [INSN_WIDTH-1:0]      rsp1_insn,
  output logic [INSN_ADDR_WIDTH-1:0] mem_addr,
  input  logic [INSN_WIDTH-1:0]      mem_insn,
  output logic [7:0]                 starve_cnt
);

  typedef enum logic [1:0] {OWN_NONE, OWN_R0, OWN_R1} owner_t;

  localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

  owner_t                     r_owner;
  logic [7:0]                 r_starve;
  logic [INSN_ADDR_WIDTH-1:0] r_hold_addr;

  logic                       w_force1;
  logic                       w_gnt0;
  logic                       w_gnt1;
  logic [INSN_ADDR_WIDTH-1:0] w_mem_addr;

  // Port 1 wins outright once it has been refused LIMIT times in a row;
  // otherwise it only gets the slot when fetch is idle.
  assign w_force1 = req1_valid && (r_starve >= LIMIT8);
  assign w_gnt1   = rst && req1_valid && (w_force1 || !req0_valid);
  assign w_gnt0   = rst && req0_valid && !w_gnt1;

  // Idle cycles replay the last address so the memory bus stays quiet.
  always_comb begin
    w_mem_addr = r_hold_addr;
    if (!rst)        w_mem_addr = '0;
    else if (w_gnt0) w_mem_addr = req0_addr;
    else if (w_gnt1) w_mem_addr = req1_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner     <= OWN_NONE;
      r_starve    <= 8'd0;
      r_hold_addr <= '0;
    end else begin
      r_hold_addr <= w_mem_addr;
      r_owner     <= w_gnt0 ? OWN_R0 : (w_gnt1 ? OWN_R1 : OWN_NONE);
      if (w_gnt1 || !req1_valid)
        r_starve <= 8'd0;
      else if (r_starve != 8'hFF)
        r_starve <= r_starve + 8'd1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign mem_addr   = w_mem_addr;
  // Reset gates responses immediately so an in-flight read is dropped.
  assign rsp0_valid = rst && (r_owner == OWN_R0);
  assign rsp1_valid = rst && (r_owner == OWN_R1);
  assign rsp0_insn  = mem_insn;
  assign rsp1_insn  = mem_insn;
  assign starve_cnt = r_starve;

endmodule

// File: tb/tb_imem_read_arbiter.sv
module tb_imem_read_arbiter;
  import imem_types_pkg::*;

  localparam int LIMIT = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [INSN_ADDR_WIDTH-1:0] req0_addr = '0, req1_addr = '0;
  logic                       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [INSN_WIDTH-1:0]      rsp0_insn, rsp1_insn, mem_insn;
  logic [INSN_ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]                 starve_cnt;

  imem_read_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_insn(rsp0_insn),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_insn(rsp1_insn),
    .mem_addr(mem_addr), .mem_insn(mem_insn), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: registers address on clk, data out next cycle.
  logic [31:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 17 + 1);
  initial mem_insn = '0;
  always @(posedge clk) mem_insn <= mem[mem_addr[7:2]];

  typedef struct { int port; logic [31:0] addr; } pend_t;
  pend_t       sb[$];
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  m_starve = 8'd0;
  logic [31:0] m_hold = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: drive inputs after the falling edge, check combinational
  // outputs and any due response, update the model, then let posedge occur.
  task automatic step(input logic r, input logic v0, input logic [31:0] a0,
                      input logic v1, input logic [31:0] a1);
    logic  g0, g1;
    logic [31:0] ea;
    pend_t p;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
    #1;
    if (!r) begin
      chk("rst_rdy0", {31'b0, req0_ready}, 0);
      chk("rst_rdy1", {31'b0, req1_ready}, 0);
      chk("rst_rsp0", {31'b0, rsp0_valid}, 0);
      chk("rst_rsp1", {31'b0, rsp1_valid}, 0);
      chk("rst_addr", mem_addr, 0);
      sb.delete();
      m_starve = 0; m_hold = 0;
      return;
    end
    if (sb.size() > 0) begin
      p = sb.pop_front();
      chk("rsp0_v", {31'b0, rsp0_valid}, (p.port == 0) ? 1 : 0);
      chk("rsp1_v", {31'b0, rsp1_valid}, (p.port == 1) ? 1 : 0);
      chk("rsp_insn", (p.port == 0) ? rsp0_insn : rsp1_insn, mem[p.addr[7:2]]);
    end else begin
      chk("idle_rsp0", {31'b0, rsp0_valid}, 0);
      chk("idle_rsp1", {31'b0, rsp1_valid}, 0);
    end
    g1 = v1 && ((m_starve >= 8'(LIMIT)) || !v0);
    g0 = v0 && !g1;
    ea = g0 ? a0 : (g1 ? a1 : m_hold);
    chk("starve", {24'b0, starve_cnt}, {24'b0, m_starve});
    chk("rdy0", {31'b0, req0_ready}, {31'b0, g0});
    chk("rdy1", {31'b0, req1_ready}, {31'b0, g1});
    chk("mem_addr", mem_addr, ea);
    if (g0 || g1) sb.push_back('{port: g0 ? 0 : 1, addr: ea});
    m_hold = ea;
    if (g1 || !v1) m_starve = 0;
    else if (m_starve != 8'hFF) m_starve = m_starve + 1;
  endtask

  initial begin
    // 1: reset with both requests valid, then release idle
    step(0, 1, 32'h4, 1, 32'h8);
    step(0, 1, 32'h4, 1, 32'h8);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // 2: fetch only
    for (int i = 0; i < 3; i++) step(1, 1, 32'(i * 4), 0, 0);
    step(1, 0, 0, 0, 0);
    // 3: contention, two full rounds
    for (int i = 0; i < 2 * (LIMIT + 1) + 2; i++)
      step(1, 1, 32'(4 * (i % 16)), 1, 32'h80 + 32'(4 * (i % 8)));
    step(1, 0, 0, 0, 0);
    // req1 dropped mid-wait clears counter
    step(1, 1, 32'h0, 1, 32'h40);
    step(1, 1, 32'h4, 1, 32'h40);
    step(1, 1, 32'h8, 0, 0);
    step(1, 1, 32'hC, 1, 32'h44);
    step(1, 0, 0, 0, 0);
    // 4: idle hold
    step(1, 1, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    // 5: reset mid-flight
    step(1, 0, 0, 1, 32'h20);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("post_rst_starve", {24'b0, starve_cnt}, 0);
    // 6: debug only stream
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 32'(i * 4));
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
